// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: rebuilds pixel/line position from hsync/vsync and tracks lock.
// Define SYNC_TIMEOUT_EN to drop lock when hsync goes missing for two line times.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        de,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        err
);

  localparam logic [16:0] H_LEN = 17'(H_TOTAL);
  localparam logic [16:0] V_LEN = 17'(V_TOTAL);
  localparam logic [15:0] H_A0  = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_A1  = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_A0  = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_A1  = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [3:0]  LF    = 4'(LOCK_FRAMES);
`ifdef SYNC_TIMEOUT_EN
  localparam logic [15:0] TO_MAX = 16'(2 * H_TOTAL - 1);
`endif

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [15:0] vcnt_q, vcnt_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        de_q, de_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;

  logic h_edge, v_edge;
  logic h_bad, v_bad;
  logic timeout, viol;
  logic in_h, in_v;

  always_comb begin
    h_edge = pix_en & hs_q & ~hsync_in;
    v_edge = h_edge & vs_q & ~vsync_in;
    hs_d   = pix_en ? hsync_in : hs_q;
    vs_d   = pix_en ? vsync_in : vs_q;
    h_bad  = h_edge & (({1'b0, hcnt_q} + 17'd1) != H_LEN);
    v_bad  = v_edge & (({1'b0, vcnt_q} + 17'd1) != V_LEN);

    timeout = 1'b0;
    hcnt_d  = hcnt_q;
    if (h_edge)
      hcnt_d = '0;
    else if (pix_en && hcnt_q != 16'hFFFF)
      hcnt_d = hcnt_q + 16'd1;
`ifdef SYNC_TIMEOUT_EN
    // Park the counter at the limit so the timeout fires once per loss.
    if (pix_en && !h_edge) begin
      if (hcnt_q == TO_MAX)
        hcnt_d = hcnt_q;
      else if (hcnt_q == TO_MAX - 16'd1)
        timeout = 1'b1;
    end
`endif

    vcnt_d = vcnt_q;
    if (v_edge)
      vcnt_d = '0;
    else if (h_edge && vcnt_q != 16'hFFFF)
      vcnt_d = vcnt_q + 16'd1;

    viol     = (state_q != SEARCH) & (h_bad | v_bad | timeout);
    state_d  = state_q;
    good_d   = good_q;
    locked_d = locked_q;
    err_d    = viol;
    if (viol || timeout) begin
      state_d  = SEARCH;
      good_d   = '0;
      locked_d = 1'b0;
    end else if (v_edge) begin
      unique case (state_q)
        SEARCH: begin
          state_d = CHECK;
          good_d  = '0;
        end
        CHECK: begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 == LF) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
        end
        LOCKED: state_d = LOCKED;
        default: begin
          state_d  = SEARCH;
          good_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end

    in_h = (hcnt_q >= H_A0) && (hcnt_q < H_A1);
    in_v = (vcnt_q >= V_A0) && (vcnt_q < V_A1);
    de_d = locked_q & in_h & in_v;
    x_d  = de_d ? hcnt_q - H_A0 : '0;
    y_d  = de_d ? vcnt_q - V_A0 : '0;
    ls_d = h_edge;
    fs_d = v_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      de_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      de_q     <= de_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a shrunken raster (20x12) driven by a
// behavioural sync source; expected outputs come from source coordinates.
module tb_vga_sync_decoder;

  localparam int HT = 20, HS = 3, HB = 2, HA = 12;
  localparam int VT = 12, VS = 2, VB = 2, VA = 6;
  localparam int LF = 2;
  localparam int HA0 = HS + HB, VA0 = VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic hsync_in = 1'b1;
  logic vsync_in = 1'b1;
  logic [15:0] x, y;
  logic de, line_start, frame_start, locked, err;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .H_BP(HB),
    .H_ACTIVE(HA), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .de(de), .line_start(line_start),
    .frame_start(frame_start), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // source raster position and geometry
  int px, ln, cur_len, cur_lines, done_len, done_lines;
  bit long_pend, short_pend, stuck_pend;
  // reference model state
  bit m_hs, m_vs, m_lock;
  int m_state, m_good, cap_px, cap_ln;
  logic [36:0] obs, expv;

  task automatic m_reset();
    m_state = 0; m_good = 0; m_lock = 0; m_hs = 0; m_vs = 0;
  endtask

  task automatic tick(input bit en);
    bit hs, vs, he, ve, bad, to, ed;
    logic [15:0] ex, ey;
    hs = (px >= HS);
    vs = (ln >= VS);
    pix_en = en; hsync_in = hs; vsync_in = vs;
    ed = m_lock && cap_px >= HA0 && cap_px < HA0 + HA &&
         cap_ln >= VA0 && cap_ln < VA0 + VA;
    ex = ed ? 16'(cap_px - HA0) : 16'd0;
    ey = ed ? 16'(cap_ln - VA0) : 16'd0;
    he = en && m_hs && !hs;
    ve = he && m_vs && !vs;
    to = 0;
`ifdef SYNC_TIMEOUT_EN
    to = en && !he && (px == 2 * HT - 1);
`endif
    bad = (m_state != 0) &&
          ((he && done_len != HT) || (ve && done_lines != VT) || to);
    if (bad || to) begin
      m_state = 0; m_good = 0; m_lock = 0;
    end else if (ve) begin
      if (m_state == 0) begin
        m_state = 1; m_good = 0;
      end else if (m_state == 1) begin
        m_good++;
        if (m_good == LF) begin m_state = 2; m_lock = 1; end
      end
    end
    expv = {ex, ey, ed, he, ve, m_lock, bad};
    @(posedge clk); #1;
    obs = {x, y, de, line_start, frame_start, locked, err};
    if (en) begin
      m_hs = hs; m_vs = vs; cap_px = px; cap_ln = ln;
      px++;
      if (px == cur_len) begin
        px = 0; done_len = cur_len; ln++;
        if (ln == cur_lines) begin
          ln = 0; done_lines = cur_lines;
          cur_lines = short_pend ? VT - 1 : VT;
          short_pend = 0;
        end
        cur_len = long_pend ? HT + 1 : (stuck_pend ? 2 * HT + 5 : HT);
        long_pend = 0; stuck_pend = 0;
      end
    end
  endtask

  task automatic test_reset();
    px = $urandom_range(0, HT - 1); ln = $urandom_range(0, VT - 1);
    cur_len = HT; cur_lines = VT; done_len = HT; done_lines = VT;
    cap_px = 0; cap_ln = 0;
    rst_n = 0;
    hsync_in = (px >= HS); vsync_in = (ln >= VS);
    repeat (3) @(posedge clk);
    #1;
    obs = {x, y, de, line_start, frame_start, locked, err};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset outputs got=%h want=0", obs);
    end
    rst_n = 1;
    m_reset();
  endtask

  task automatic test_lock(input string nm, input int mode);
    int n = 0, fs_cnt = 0, errs = 0;
    bit got = 0, en;
    while (!got && n < 12 * FRAME) begin
      en = (mode == 0) ? 1'b1 : (n % 2 == 0);
      tick(en);
      n++;
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL %s cyc %0d got=%h want=%h", nm, n, obs, expv);
      end
      if (frame_start) fs_cnt++;
      if (err) errs++;
      if (locked) got = 1;
    end
    vectors++;
    if (!got || fs_cnt != 3 || !frame_start || errs != 0) begin
      miscompares++;
      $display("FAIL %s lock got=%0d fs=%0d errs=%0d want lock at fs 3",
               nm, got, fs_cnt, errs);
    end
  endtask

  task automatic test_coords();
    int de_cnt = 0, max_x = 0, max_y = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL coords cyc %0d got=%h want=%h", i, obs, expv);
      end
      if (de) begin
        de_cnt++;
        if (int'(x) > max_x) max_x = int'(x);
        if (int'(y) > max_y) max_y = int'(y);
      end
    end
    vectors++;
    if (de_cnt != HA * VA || max_x != HA - 1 || max_y != VA - 1) begin
      miscompares++;
      $display("FAIL coords de=%0d maxx=%0d maxy=%0d want %0d %0d %0d",
               de_cnt, max_x, max_y, HA * VA, HA - 1, VA - 1);
    end
  endtask

  task automatic test_bad_line();
    int n = 0;
    bit seen = 0;
    long_pend = 1;
    while (!seen && n < 3 * HT + 4) begin
      tick(1'b1);
      n++;
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL bad_line cyc %0d got=%h want=%h", n, obs, expv);
      end
      if (err) seen = 1;
    end
    vectors++;
    if (!seen || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_line err=%0d locked=%b want err 1 locked 0",
               seen, locked);
    end
    test_lock("bad_line_relock", 0);
  endtask

  task automatic test_bad_frame();
    int n = 0, de_unl = 0;
    bit seen = 0, at_v = 0, got = 0;
    short_pend = 1;
    while (!seen && n < 3 * FRAME) begin
      tick(1'b1);
      n++;
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL bad_frame cyc %0d got=%h want=%h", n, obs, expv);
      end
      if (err) begin seen = 1; at_v = frame_start; end
    end
    n = 0;
    while (!got && n < 5 * FRAME) begin
      tick(1'b1);
      n++;
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL bad_frame relock cyc %0d got=%h want=%h", n, obs, expv);
      end
      if (locked) got = 1;
      else if (de) de_unl++;
    end
    vectors++;
    if (!seen || !at_v || de_unl != 0 || !got) begin
      miscompares++;
      $display("FAIL bad_frame err=%0d atv=%0d de_unlocked=%0d relock=%0d",
               seen, at_v, de_unl, got);
    end
  endtask

  task automatic test_gating();
    int n = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    m_reset();
    test_lock("gating_lock", 1);
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick($urandom_range(0, 3) != 0);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL gating_rand cyc %0d got=%h want=%h", i, obs, expv);
      end
      if (de) n++;
    end
    vectors++;
    if (n == 0) begin
      miscompares++;
      $display("FAIL gating_rand de_cycles got=0 want>0");
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(ln == VT / 2 && px == HT / 2) && n < 2 * FRAME) begin
      tick(1'b1);
      n++;
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reset_mid run cyc %0d got=%h want=%h", n, obs, expv);
      end
    end
    rst_n = 0;
    #1;
    obs = {x, y, de, line_start, frame_start, locked, err};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_mid async got=%h want=0", obs);
    end
    @(posedge clk); #1;
    obs = {x, y, de, line_start, frame_start, locked, err};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_mid held got=%h want=0", obs);
    end
    rst_n = 1;
    m_reset();
    test_lock("reset_relock", 0);
  endtask

`ifdef SYNC_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    bit seen = 0;
    stuck_pend = 1;
    while (!seen && n < 4 * HT + 8) begin
      tick(1'b1);
      n++;
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL timeout cyc %0d got=%h want=%h", n, obs, expv);
      end
      if (err) seen = 1;
    end
    vectors++;
    if (!seen || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout err=%0d locked=%b want err 1 locked 0",
               seen, locked);
    end
    test_lock("timeout_relock", 0);
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    long_pend = 0; short_pend = 0; stuck_pend = 0;
    m_reset();
    test_reset();
    test_lock("lock", 0);
    test_coords();
    test_bad_line();
    test_bad_frame();
    test_gating();
    test_reset_mid();
`ifdef SYNC_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
